separacion: RTL and testbench
=============================

# separacion

Field splitter for the calculator datapath and the inverse of the operand packer. It accepts packed 10-bit operand words `{a[4:0], b[4:0]}` through a valid/ready handshake and buffers up to two of them. It re-emits each word as two consecutive 5-bit beats on a narrow output stream: `a` (high field) first, then `b` (low field). It sits between the packed-operand bus and the 5-bit operand consumers of the ALU.

## Interface
Parameters:
- `DEPTH`, default 2: input FIFO entries. Fixed at 2; other values are not supported.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  10: packed word; `[9:5]` = a, `[4:0]` = b.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: block can accept a word this cycle.
- `out_data`  out  5: current field.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts the current field.
- `out_last`  out  1: current beat is the low field (b), the last beat of its word.
- `out_zero`  out  1: present only with `SEPARACION_ZERO_FLAG_EN`; see Configuration.

## Operation
- Storage is a 2-entry FIFO of 10-bit words with write pointer, read pointer and a 2-bit count (0..2). Pointers wrap modulo 2.
- Push: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer and increments the count.
- `in_ready = !rst && (count < 2)`. It depends only on registered state; there is no combinational path from `out_ready`.
- Phase FSM over the head entry:
  - EMPTY: count == 0. `out_valid=0`, `out_data=0`, `out_last=0`.
  - HI: head entry present. `out_data = head[9:5]`, `out_valid=1`, `out_last=0`.
  - LO: `out_data = head[4:0]`, `out_valid=1`, `out_last=1`.
- Transitions:
  - EMPTY→HI on push.
  - HI→LO on `out_valid && out_ready`.
  - LO on `out_ready`: pop the head, then go to HI if the resulting count ≥ 1, else EMPTY.
- A field is held stable while `out_valid && !out_ready`. The consumer may stall indefinitely without loss.
- Simultaneous push and pop in LO with count 1: the count stays 1, the new word becomes the head, and the phase goes to HI next cycle.
- Count 2: `in_ready=0` even if a pop occurs that cycle. The slot frees on the following cycle.
- A push attempted while `in_ready=0` is ignored. The upstream is required to hold its word.
- Reset mid-stream: clears the FIFO, pointers, count and phase to EMPTY. Any partially emitted word is discarded, with no trailing low beat.

## Timing
- Reset values: `in_ready=0` while `rst` is high and 1 on the first cycle after; `out_valid=0`, `out_last=0`, `out_data=0`, `out_zero=0`.
- Latency: a word pushed at edge N drives its high field in the cycle after edge N.
- With `out_ready` held high, the low field follows one cycle later.
- Sustained throughput: 1 word per 2 cycles, limited by the output. Input stalls once 2 words are pending.
- All outputs are combinational decodes of registers only, with no input-to-output combinational paths.

## Configuration
- `SEPARACION_ZERO_FLAG_EN` defined: port `out_zero` exists and equals `out_valid && (out_data == 5'd0)`. Its reset value is 0.
- Not defined: the `out_zero` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then push `10'b10101_00011` with `out_ready=1` → next cycle `out_data=5'b10101`, `out_last=0`; following cycle `out_data=5'b00011`, `out_last=1`; then `out_valid=0`.
- `out_ready=0`, push 3 words back-to-back → first 2 accepted, `in_ready=0` from the cycle after the 2nd push; the 3rd is held by the source; `out_data` stays at word0's high field.
- Release `out_ready` after the FIFO fills → beats appear in order hi0, lo0, hi1, lo1, hi2, lo2 with no gaps and no duplicates. `in_ready` returns 1 the cycle after lo0 is accepted.
- Push a new word in the same cycle lo0 is accepted with count 1 → count stays 1; the next cycle shows hi of the new word.
- Assert `rst` while in LO → next cycle `out_valid=0` and `in_ready=0`; after deassert, `in_ready=1` and no stale beats are emitted.
- With `SEPARACION_ZERO_FLAG_EN`, push `10'b00000_01001` → `out_zero=1` on the high beat and 0 on the low beat; `out_zero=0` when idle.

Source files
------------

// File: rtl/separacion_if.sv
// Packed-operand input stream and 5-bit field output stream of the field splitter.
// out_zero exists only when SEPARACION_ZERO_FLAG_EN is defined.
interface separacion_if;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
`ifdef SEPARACION_ZERO_FLAG_EN
  logic       out_zero;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_zero
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_zero
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
`endif
endinterface

// File: rtl/separacion.sv
// Splits buffered {a,b} words into a-then-b 5-bit beats; hi beat 1 cycle after push, 2 words buffered.
// in_ready drops at 2 pending words (registered count only); out fields hold under stall. Option: SEPARACION_ZERO_FLAG_EN.
module separacion #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  separacion_if.slave io
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } phase_t;

  localparam logic [1:0] FULL = DEPTH[1:0];

  logic [9:0] mem_q [DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  phase_t     phase_q;
  logic       push;
  logic       pop;
  logic [9:0] head;

  assign io.in_ready = !rst && (count_q < FULL);
  assign push        = io.in_valid && io.in_ready;
  assign pop         = (phase_q == LO) && io.out_ready;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      phase_q  <= EMPTY;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      case (phase_q)
        EMPTY:   if (push) phase_q <= HI;
        HI:      if (io.out_ready) phase_q <= LO;
        // the head is popped here; a same-cycle push keeps the stream going
        LO:      if (io.out_ready) phase_q <= (count_d != 2'd0) ? HI : EMPTY;
        default: phase_q <= EMPTY;
      endcase
    end
  end

  assign io.out_valid = (phase_q != EMPTY);
  assign io.out_last  = (phase_q == LO);
  assign io.out_data  = (phase_q == HI) ? head[9:5] :
                        (phase_q == LO) ? head[4:0] : 5'd0;

`ifdef SEPARACION_ZERO_FLAG_EN
  assign io.out_zero  = io.out_valid && (io.out_data == 5'd0);
`endif

endmodule

// File: tb/tb_separacion.sv
// Directed vector table plus randomized traffic against a word-queue reference model.
module tb_separacion;
  logic clk = 1'b0;
  logic rst;

  separacion_if bus();

  separacion #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [9:0] id;
    logic       ordy;
    logic       e_rdy;
    logic       e_vld;
    logic [4:0] e_dat;
    logic       e_last;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rdy, input logic e_vld,
                          input logic [4:0] e_dat, input logic e_last);
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, e_rdy});
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, e_vld});
    chk({tag, ".out_data"},  {27'd0, bus.out_data},  {27'd0, e_dat});
    chk({tag, ".out_last"},  {31'd0, bus.out_last},  {31'd0, e_last});
`ifdef SEPARACION_ZERO_FLAG_EN
    chk({tag, ".out_zero"},  {31'd0, bus.out_zero},
        {31'd0, e_vld && (e_dat == 5'd0)});
`endif
  endtask

  localparam logic [9:0] W0 = 10'b11110_00001;
  localparam logic [9:0] W1 = 10'b01010_10101;
  localparam logic [9:0] W2 = 10'b00111_00111;
  localparam logic [9:0] WT = 10'b10101_00011;
  localparam logic [9:0] WZ = 10'b00000_01001;

  vec_t vt[$];

  task automatic addv(input logic r, input logic iv, input logic [9:0] id, input logic ordy,
                      input logic er, input logic ev, input logic [4:0] ed, input logic el);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_rdy = er; v.e_vld = ev; v.e_dat = ed; v.e_last = el;
    vt.push_back(v);
  endtask

  logic [9:0] mq[$];
  bit         hi_done;

  initial begin
    logic       e_vld;
    logic       e_rdy;
    logic       e_last;
    logic [4:0] e_dat;
    logic [9:0] head;
    logic [9:0] rd;
    bit         do_push;
    bit         do_beat;

    // reset, single word with ready high
    addv(1, 0, 10'd0, 1,  0, 0, 5'd0, 0);
    addv(0, 1, WT,    1,  1, 0, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 1, 5'b10101, 0);
    addv(0, 0, 10'd0, 1,  1, 1, 5'b00011, 1);
    addv(0, 0, 10'd0, 0,  1, 0, 5'd0, 0);
    // stall output, three words back to back, then release
    addv(0, 1, W0, 0,  1, 0, 5'd0, 0);
    addv(0, 1, W1, 0,  1, 1, W0[9:5], 0);
    addv(0, 1, W2, 0,  0, 1, W0[9:5], 0);
    addv(0, 1, W2, 0,  0, 1, W0[9:5], 0);
    addv(0, 1, W2, 1,  0, 1, W0[9:5], 0);
    addv(0, 1, W2, 1,  0, 1, W0[4:0], 1);
    addv(0, 1, W2, 1,  1, 1, W1[9:5], 0);
    addv(0, 0, 10'd0, 1,  0, 1, W1[4:0], 1);
    addv(0, 0, 10'd0, 1,  1, 1, W2[9:5], 0);
    addv(0, 0, 10'd0, 1,  1, 1, W2[4:0], 1);
    addv(0, 0, 10'd0, 1,  1, 0, 5'd0, 0);
    // push in the same cycle the low beat of a lone word is taken
    addv(0, 1, W0, 1,  1, 0, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 1, W0[9:5], 0);
    addv(0, 1, W1, 1,  1, 1, W0[4:0], 1);
    addv(0, 0, 10'd0, 1,  1, 1, W1[9:5], 0);
    addv(0, 0, 10'd0, 1,  1, 1, W1[4:0], 1);
    addv(0, 0, 10'd0, 0,  1, 0, 5'd0, 0);
    // reset while in the low phase
    addv(0, 1, W2, 1,  1, 0, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 1, W2[9:5], 0);
    addv(1, 0, 10'd0, 0,  0, 1, W2[4:0], 1);
    addv(1, 0, 10'd0, 1,  0, 0, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 0, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 0, 5'd0, 0);
    // word with a zero high field
    addv(0, 1, WZ, 1,  1, 0, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 1, 5'd0, 0);
    addv(0, 0, 10'd0, 1,  1, 1, 5'b01001, 1);
    addv(0, 0, 10'd0, 1,  1, 0, 5'd0, 0);

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 10'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      rst           = vt[i].rst;
      bus.in_valid  = vt[i].iv;
      bus.in_data   = vt[i].id;
      bus.out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d", i), {28'd0, bus.in_ready, bus.out_valid, bus.out_last, 1'b0},
          {28'd0, vt[i].e_rdy, vt[i].e_vld, vt[i].e_last, 1'b0});
      chk_outs($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_vld, vt[i].e_dat, vt[i].e_last);
      @(posedge clk);
      @(negedge clk);
    end

    // randomized traffic; model: queue of pending words plus which half is showing
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    hi_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rd = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 5) == 0) rd[9:5] = 5'd0;
      if ($urandom_range(0, 5) == 0) rd[4:0] = 5'd0;
      bus.in_data   = rd;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_vld  = (mq.size() != 0);
      e_rdy  = (mq.size() < 2);
      head   = e_vld ? mq[0] : 10'd0;
      e_dat  = !e_vld ? 5'd0 : (hi_done ? head[4:0] : head[9:5]);
      e_last = e_vld && hi_done;
      chk_outs($sformatf("rnd%0d", c), e_rdy, e_vld, e_dat, e_last);
      do_push = bus.in_valid && e_rdy;
      do_beat = e_vld && bus.out_ready;
      @(posedge clk);
      if (do_beat) begin
        if (hi_done) begin
          void'(mq.pop_front());
          hi_done = 1'b0;
        end else begin
          hi_done = 1'b1;
        end
      end
      if (do_push) mq.push_back(rd);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
